imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the 1024x18 instruction memory: receives a program image as a byte stream and writes it word by word into the instruction memory's write port.
- Holds the processor core in reset while loading. On completion it releases the core, so the core fetches the new program from address 0.
- Sits between the host byte link (valid/ready) and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory address width.
- IWIDTH, 18, instruction word width; only 18 is supported.
- DEPTH, 1024, maximum number of words; equals 2**ADDR_W.

Ports:
- Clk_In  input  1  system clock; the only clock in the block.
- Rst_n_In  input  1  reset, asynchronous assert, active-low.
- Start_In  input  1  one-cycle pulse that begins a load session.
- Byte_In  input  8  stream data.
- Byte_Valid_In  input  1  Byte_In is valid.
- Byte_Ready_Out  output  1  loader can accept a byte.
- Wr_En_Out  output  1  one-cycle write strobe to the instruction memory.
- Wr_Add_Out  output  ADDR_W  write address.
- Wr_Data_Out  output  IWIDTH  write data.
- Core_Hold_Out  output  1  holds the core in reset while high.
- Busy_Out  output  1  a session is in progress.
- Done_Out  output  1  load completed (level).
- Err_Out  output  1  load aborted (level).
- Word_Count_Out  output  ADDR_W+1  number of words written in the current session.

Behaviour:
- Interface: one clock, Clk_In. Reset Rst_n_In is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, address counter and length register 0.
- Handshake: a byte is consumed on a rising edge where Byte_Valid_In=1 and Byte_Ready_Out=1. Byte_Ready_Out is registered. It is high only in LEN_HI, LEN_LO, B0, B1, B2 and CSUM.
- Stream format:
  - Two length bytes, big-endian; N = {hi[2:0], lo}.
  - Then N words of 3 bytes each: byte0[1:0] -> data[17:16], byte1 -> data[15:8], byte2 -> data[7:0]. byte0[7:2] is ignored.
- States:
  - IDLE: Start_In=1 -> LEN_HI; clear the counter; Core_Hold_Out=1, Busy_Out=1.
  - LEN_HI: on accept, capture hi -> LEN_LO.
  - LEN_LO: on accept -> B0 if 1 <= N <= DEPTH; otherwise -> ERR (covers N=0, N>DEPTH, and hi[7:3] nonzero).
  - B0, B1, B2: each accepts one byte into the word register. B2 accept -> WRITE.
  - WRITE: exactly one cycle.
    - Wr_En_Out=1 with Wr_Add_Out = counter and Wr_Data_Out = assembled word, all registered and stable in the same cycle.
    - Counter increments after the cycle.
    - If the written address was N-1 -> CSUM (macro defined) or DONE; otherwise -> B0.
    - Byte_Ready_Out=0, so an incoming byte waits and is not lost.
  - DONE: Done_Out=1, Core_Hold_Out=0, Busy_Out=0. Start_In -> new session (Done_Out clears).
  - ERR: Err_Out=1, Core_Hold_Out stays 1, Busy_Out=0. Only Start_In or reset leaves ERR; Start_In begins a new session.
- Start_In while Busy_Out=1 is ignored.
- Wr_Add_Out never exceeds DEPTH-1; there is no wrap-around.
- Word_Count_Out equals the counter: it increments in the cycle after each WRITE and holds its value in DONE and ERR.
- Throughput: at most one word per 4 cycles (3 accepts + WRITE).
- Reset mid-session: immediate return to IDLE, Wr_En_Out=0, no further writes. Words already written remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, enter CSUM and accept one byte. Compare it with a running XOR of all word bytes; length bytes are excluded. Match -> DONE; mismatch -> ERR. All words are already written in either case.
- Undefined: no CSUM state; after the last WRITE go directly to DONE.

Test Plan:
1. Start, then stream 00 02 | 00 A1 00 | 01 E0 71 (plus 31 if checksum enabled) -> writes (0, 0x0A100) and (1, 0x1E071); Done_Out=1, Word_Count_Out=2, Core_Hold_Out falls to 0.
2. Length bytes 00 00, and separately 04 01 -> Err_Out=1, no Wr_En_Out pulse, Core_Hold_Out stays 1. Length 04 00 followed by 1024 words -> last write at address 1023, then Done_Out=1, Word_Count_Out=1024.
3. Random gaps on Byte_Valid_In, with a byte presented during WRITE -> byte not consumed until Byte_Ready_Out=1; written data identical to scenario 1.
4. Rst_n_In low after 4 accepted bytes -> all outputs 0 asynchronously, no writes afterward. A new Start plus the full stream then completes normally.
5. Start_In pulsed mid-session -> ignored; the session completes with the original N.
6. Checksum enabled, scenario 1 with final byte 30 -> both words written, Err_Out=1, Done_Out=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the two buses of the instruction-memory loader:
//   - host byte link: Byte_In, Byte_Valid_In (host -> loader), Byte_Ready_Out (loader -> host)
//   - memory write port: Wr_En_Out, Wr_Add_Out, Wr_Data_Out (loader -> memory)
// Modports:
//   slave  - the loader (consumes bytes, drives the write port)
//   master - the host/memory side
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int IWIDTH = 18
);
    logic [7:0]        Byte_In;
    logic              Byte_Valid_In;
    logic              Byte_Ready_Out;
    logic              Wr_En_Out;
    logic [ADDR_W-1:0] Wr_Add_Out;
    logic [IWIDTH-1:0] Wr_Data_Out;

    modport slave (
        input  Byte_In,
        input  Byte_Valid_In,
        output Byte_Ready_Out,
        output Wr_En_Out,
        output Wr_Add_Out,
        output Wr_Data_Out
    );

    modport master (
        output Byte_In,
        output Byte_Valid_In,
        input  Byte_Ready_Out,
        input  Wr_En_Out,
        input  Wr_Add_Out,
        input  Wr_Data_Out
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Writes a program image, received as a byte stream, into the 1024x18
// instruction memory and holds the core in reset while doing so.
// Stream: LEN_HI, LEN_LO (N = {hi[2:0], lo}), then N words of 3 bytes
// (byte0[1:0], byte1, byte2 -> data[17:0]).
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// byte equal to the XOR of all word bytes; a mismatch ends in ERR.
// Ports:
//   Clk_In, Rst_n_In (async, active-low)
//   Start_In        - one-cycle pulse, starts a session when not busy
//   bus (slave)     - byte link + instruction memory write port
//   Core_Hold_Out   - core held in reset while high
//   Busy_Out        - session in progress
//   Done_Out        - load completed (level)
//   Err_Out         - load aborted (level)
//   Word_Count_Out  - words written in the current session
//
// state  | meaning
// IDLE   | after reset, waiting for Start_In
// LEN_HI | accepting the high length byte
// LEN_LO | accepting the low length byte, validating N
// B0..B2 | accepting the three bytes of one word
// WRITE  | one-cycle write strobe to the memory
// CSUM   | accepting the checksum byte (checksum build only)
// DONE   | load complete, core released
// ERR    | load aborted, core still held
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int IWIDTH = 18,
    parameter int DEPTH  = 1024
) (
    input  logic              Clk_In,
    input  logic              Rst_n_In,
    input  logic              Start_In,
    imem_loader_if.slave      bus,
    output logic              Core_Hold_Out,
    output logic              Busy_Out,
    output logic              Done_Out,
    output logic              Err_Out,
    output logic [ADDR_W:0]   Word_Count_Out
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } state_t;

    state_t state, next;

    logic [7:0]        len_hi;
    logic [ADDR_W:0]   len;
    logic [1:0]        word_hi;
    logic [7:0]        word_mid;
    logic [ADDR_W:0]   n_len;
    logic              accept;
    logic              len_ok;
    logic              last_word;
    logic              start_go;
    logic              ready_nxt;
    logic              busy_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = bus.Byte_Valid_In && bus.Byte_Ready_Out;
    assign n_len     = {len_hi[2:0], bus.Byte_In};
    assign len_ok    = (len_hi[7:3] == 5'd0) && (n_len != '0) && (n_len <= DEPTH_L);
    assign last_word = (Word_Count_Out == len - 1'b1);

    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) state <= IDLE;
        else           state <= next;
    end

    always_comb begin
        next      = state;
        start_go  = 1'b0;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (Start_In) begin
                    next     = LEN_HI;
                    start_go = 1'b1;
                end
            end
            LEN_HI: if (accept) next = LEN_LO;
            LEN_LO: if (accept) next = len_ok ? B0 : ERR;
            B0:     if (accept) next = B1;
            B1:     if (accept) next = B2;
            B2:     if (accept) next = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next = CSUM;
`else
                    next = DONE;
`endif
                end else begin
                    next = B0;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (accept) next = (bus.Byte_In == csum) ? DONE : ERR;
`endif
            default: next = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        case (next)
            LEN_HI, LEN_LO, B0, B1, B2: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
`endif
            WRITE:   busy_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            bus.Byte_Ready_Out <= 1'b0;
            bus.Wr_En_Out      <= 1'b0;
            bus.Wr_Add_Out     <= '0;
            bus.Wr_Data_Out    <= '0;
            Core_Hold_Out      <= 1'b0;
            Busy_Out           <= 1'b0;
            Done_Out           <= 1'b0;
            Err_Out            <= 1'b0;
            Word_Count_Out     <= '0;
            len_hi             <= '0;
            len                <= '0;
            word_hi            <= '0;
            word_mid           <= '0;
        end else begin
            bus.Byte_Ready_Out <= ready_nxt;
            bus.Wr_En_Out      <= (next == WRITE);
            Busy_Out           <= busy_nxt;
            Core_Hold_Out      <= busy_nxt || (next == ERR);
            Done_Out           <= (next == DONE);
            Err_Out            <= (next == ERR);

            if (start_go) Word_Count_Out <= '0;
            else if (state == WRITE) Word_Count_Out <= Word_Count_Out + 1'b1;

            if (accept) begin
                case (state)
                    LEN_HI: len_hi <= bus.Byte_In;
                    LEN_LO: len    <= n_len;
                    B0:     word_hi  <= bus.Byte_In[1:0];
                    B1:     word_mid <= bus.Byte_In;
                    B2: begin
                        // Address and data are registered together with the
                        // strobe, so all three are valid in the WRITE cycle.
                        bus.Wr_Add_Out  <= Word_Count_Out[ADDR_W-1:0];
                        bus.Wr_Data_Out <= {word_hi, word_mid, bus.Byte_In};
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            csum <= '0;
        end else if (start_go) begin
            csum <= '0;
        end else if (accept && (state == B0 || state == B1 || state == B2)) begin
            csum <= csum ^ bus.Byte_In;
        end
    end
`endif

endmodule
